zero_run_reporter: RTL and testbench

- Sits directly downstream of the zero-detector FSM and consumes its registered `detection` level.
- Measures each contiguous detection run in clock cycles and hands each completed run length out as a record over a valid/ready interface.
- Keeps an event count and a maximum-run statistic, and raises an alarm when the current run reaches a threshold.
- Input is already synchronous to `clk`; no synchronizer is required.

---
 rtl/zero_run_reporter.sv | 126 ++++++++++++
 tb/tb_zero_run_reporter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/zero_run_reporter.sv
// Measures contiguous detection runs, hands completed run lengths out through a
// single-entry valid/ready holding register, and tracks run statistics and alarm.
module zero_run_reporter #(
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16,
  parameter int ALARM_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             detection,
  input  logic             clr,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [LEN_W-1:0] rpt_len,
  output logic             rpt_sat,
  output logic [CNT_W-1:0] event_count,
  output logic [LEN_W-1:0] max_len,
  output logic             alarm,
  output logic             overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [LEN_W-1:0] ALARM_VAL = LEN_W'(ALARM_LEN);

  state_t           state, state_next;
  logic [LEN_W-1:0] run_cnt, run_cnt_next, run_cnt_inc;
  logic             sat_flag, sat_flag_next;
  logic             rpt_valid_next, rpt_sat_next, alarm_next, overflow_next;
  logic [LEN_W-1:0] rpt_len_next, max_len_next;
  logic [CNT_W-1:0] event_count_next;
  logic             slot_free, run_end;

  assign slot_free   = !rpt_valid || rpt_ready;
  assign run_end     = (state == RUN) && !detection;
  assign run_cnt_inc = (run_cnt == LEN_MAX) ? run_cnt : run_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      sat_flag    <= 1'b0;
      rpt_valid   <= 1'b0;
      rpt_len     <= '0;
      rpt_sat     <= 1'b0;
      event_count <= '0;
      max_len     <= '0;
      alarm       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      run_cnt     <= run_cnt_next;
      sat_flag    <= sat_flag_next;
      rpt_valid   <= rpt_valid_next;
      rpt_len     <= rpt_len_next;
      rpt_sat     <= rpt_sat_next;
      event_count <= event_count_next;
      max_len     <= max_len_next;
      alarm       <= alarm_next;
      overflow    <= overflow_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (detection)  state_next = RUN;
      RUN:  if (!detection) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_comb begin
    run_cnt_next     = run_cnt;
    sat_flag_next    = sat_flag;
    rpt_valid_next   = rpt_valid;
    rpt_len_next     = rpt_len;
    rpt_sat_next     = rpt_sat;
    event_count_next = event_count;
    max_len_next     = max_len;
    alarm_next       = alarm;
    overflow_next    = overflow;

    case (state)
      IDLE: begin
        if (detection) begin
          run_cnt_next  = LEN_W'(1);
          sat_flag_next = 1'b0;
          alarm_next    = (ALARM_LEN == 1);
          if (event_count != CNT_MAX) event_count_next = event_count + 1'b1;
        end
      end
      RUN: begin
        if (detection) begin
          run_cnt_next = run_cnt_inc;
          if (run_cnt == LEN_MAX) sat_flag_next = 1'b1;
          if (run_cnt_inc == ALARM_VAL) alarm_next = 1'b1;
        end else begin
          alarm_next   = 1'b0;
          run_cnt_next = '0;
          if (run_cnt > max_len) max_len_next = run_cnt;
          // A full, unaccepted holding register keeps its record; the new one is lost.
          if (slot_free) begin
            rpt_valid_next = 1'b1;
            rpt_len_next   = run_cnt;
            rpt_sat_next   = sat_flag;
          end else begin
            overflow_next = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (!run_end && rpt_valid && rpt_ready) rpt_valid_next = 1'b0;

    if (clr) begin
      event_count_next = '0;
      max_len_next     = '0;
      overflow_next    = 1'b0;
    end
  end

endmodule

// File: tb/tb_zero_run_reporter.sv
// Self-checking bench for zero_run_reporter: vector table, directed corner
// sequences and a randomized run checked against a run-level reference model.
module tb_zero_run_reporter;
  localparam int LEN_W     = 8;
  localparam int CNT_W     = 16;
  localparam int ALARM_LEN = 16;
  localparam int LEN_MAX   = (1 << LEN_W) - 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, detection, clr, rpt_ready;
  logic             rpt_valid, rpt_sat, alarm, overflow;
  logic [LEN_W-1:0] rpt_len, max_len;
  logic [CNT_W-1:0] event_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a run is just an unbounded length, saturation applied on report.
  bit m_in_run, m_valid, m_rsat, m_ovf;
  int m_len, m_ec, m_max, m_rlen;

  typedef struct {
    logic d, c, r;
    logic ev; int el; logic es; int eec; int emax; logic ea; logic eo;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  zero_run_reporter #(.LEN_W(LEN_W), .CNT_W(CNT_W), .ALARM_LEN(ALARM_LEN)) dut (
    .clk(clk), .reset(reset), .detection(detection), .clr(clr), .rpt_ready(rpt_ready),
    .rpt_valid(rpt_valid), .rpt_len(rpt_len), .rpt_sat(rpt_sat), .event_count(event_count),
    .max_len(max_len), .alarm(alarm), .overflow(overflow)
  );

  function automatic int satLen(int n);
    return (n > LEN_MAX) ? LEN_MAX : n;
  endfunction

  task automatic modelReset();
    m_in_run = 0; m_valid = 0; m_rsat = 0; m_ovf = 0;
    m_len = 0; m_ec = 0; m_max = 0; m_rlen = 0;
  endtask

  task automatic modelStep(input bit d, input bit c, input bit r);
    bit free, hs;
    free = !m_valid || r;
    hs   = m_valid && r;
    if (m_in_run && !d) begin
      m_in_run = 0;
      if (satLen(m_len) > m_max) m_max = satLen(m_len);
      if (free) begin
        m_valid = 1; m_rlen = satLen(m_len); m_rsat = (m_len > LEN_MAX);
      end else begin
        m_ovf = 1;
      end
    end else begin
      if (hs) m_valid = 0;
      if (d) begin
        if (!m_in_run) begin
          m_in_run = 1; m_len = 0;
          if (m_ec < CNT_MAX) m_ec++;
        end
        m_len++;
      end
    end
    if (c) begin m_ec = 0; m_max = 0; m_ovf = 0; end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input bit ev, input int el, input bit es,
                             input int eec, input int emax, input bit ea, input bit eo);
    vectors++;
    if (rpt_valid !== ev || rpt_len !== LEN_W'(el) || rpt_sat !== es ||
        event_count !== CNT_W'(eec) || max_len !== LEN_W'(emax) || alarm !== ea || overflow !== eo) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%b len=%0d sat=%b ec=%0d max=%0d alarm=%b ovf=%b expected v=%b len=%0d sat=%b ec=%0d max=%0d alarm=%b ovf=%b",
               name, rpt_valid, rpt_len, rpt_sat, event_count, max_len, alarm, overflow,
               ev, el, es, eec, emax, ea, eo);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_valid, m_rlen, m_rsat, m_ec, m_max,
                m_in_run && (m_len >= ALARM_LEN), m_ovf);
  endtask

  task automatic applyStimulus(input string name, input bit d, input bit c, input bit r);
    detection = d; clr = c; rpt_ready = r;
    @(posedge clk);
    modelStep(d, c, r);
    #1;
    checkModel(name);
  endtask

  task automatic doReset(input string name);
    detection = 0; clr = 0; rpt_ready = 0;
    reset = 1;
    #1;
    checkOutput(name, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit d;
    reset = 1; detection = 0; clr = 0; rpt_ready = 0;
    modelReset();
    #3;
    checkOutput("reset_state", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 0;

    tbl[0] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 1, 3, 0, 1, 3, 0, 0};
    tbl[4] = '{0, 0, 1, 0, 3, 0, 1, 3, 0, 0};
    tbl[5] = '{1, 1, 1, 0, 3, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("tbl_model_%0d", i), tbl[i].d, tbl[i].c, tbl[i].r);
      checkOutput($sformatf("tbl_%0d", i), tbl[i].ev, tbl[i].el, tbl[i].es,
                  tbl[i].eec, tbl[i].emax, tbl[i].ea, tbl[i].eo);
    end

    // Backpressure: second record is dropped while the first is held.
    doReset("bp_reset");
    repeat (2) applyStimulus("bp_run2", 1, 0, 0);
    repeat (2) applyStimulus("bp_gap", 0, 0, 0);
    repeat (5) applyStimulus("bp_run5", 1, 0, 0);
    applyStimulus("bp_end5", 0, 0, 0);
    checkValue("bp_len_held", rpt_len, 2);
    checkValue("bp_overflow", overflow, 1);
    checkValue("bp_max_len", max_len, 5);
    checkValue("bp_event_count", event_count, 2);
    applyStimulus("bp_handshake", 0, 0, 1);
    checkValue("bp_valid_after_hs", rpt_valid, 0);
    applyStimulus("bp_idle", 0, 0, 1);

    // Handshake and run end on the same edge.
    doReset("sim_reset");
    repeat (4) applyStimulus("sim_run4", 1, 0, 0);
    repeat (2) applyStimulus("sim_gap", 0, 0, 0);
    repeat (6) applyStimulus("sim_run6", 1, 0, 0);
    applyStimulus("sim_end6", 0, 0, 1);
    checkValue("sim_valid", rpt_valid, 1);
    checkValue("sim_len", rpt_len, 6);
    checkValue("sim_overflow", overflow, 0);

    // Alarm rise at ALARM_LEN and fall at run end.
    doReset("alarm_reset");
    for (int i = 1; i <= 20; i++) begin
      applyStimulus("alarm_run", 1, 0, 1);
      if (i == 15) checkValue("alarm_before", alarm, 0);
      if (i == 16) checkValue("alarm_at", alarm, 1);
    end
    applyStimulus("alarm_end", 0, 0, 1);
    checkValue("alarm_fall", alarm, 0);
    checkValue("alarm_len", rpt_len, 20);

    // Run length saturation.
    repeat (300) applyStimulus("sat_run", 1, 0, 1);
    applyStimulus("sat_end", 0, 0, 1);
    checkValue("sat_len", rpt_len, LEN_MAX);
    checkValue("sat_flag", rpt_sat, 1);
    checkValue("sat_max", max_len, LEN_MAX);

    // Reset mid-run with alarm set and a record pending.
    doReset("mid_pre_reset");
    repeat (3) applyStimulus("mid_run3", 1, 0, 0);
    applyStimulus("mid_end3", 0, 0, 0);
    repeat (17) applyStimulus("mid_run17", 1, 0, 0);
    checkValue("mid_alarm_set", alarm, 1);
    checkValue("mid_pending", rpt_valid, 1);
    doReset("mid_run_reset");
    repeat (2) applyStimulus("post_reset_run2", 1, 0, 1);
    applyStimulus("post_reset_end", 0, 0, 1);
    checkValue("post_reset_len", rpt_len, 2);
    checkValue("post_reset_valid", rpt_valid, 1);

    // Randomized runs, clears and backpressure.
    doReset("rand_reset");
    d = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      applyStimulus("random", d, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
